// File: rtl/vscpu_pkg.sv
// Shared definitions for the VerySimpleCPU interrupt controller: register window offsets and FSM states.
// Pure declarations, no logic; imported by the controller files.
package vscpu_pkg;

    localparam logic [2:0] OFF_MASK = 3'd0;
    localparam logic [2:0] OFF_PEND = 3'd1;
    localparam logic [2:0] OFF_EOI  = 3'd2;
    localparam logic [2:0] OFF_ACT  = 3'd3;
    localparam logic [2:0] OFF_EDGE = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/vscpu_intc_if.sv
// CPU-side bus between VerySimpleCPU and its interrupt controller: snooped writes, register reads, request/ack.
// No flow control; the CPU drives, the controller answers combinationally or from registers.
interface vscpu_intc_if #(
    parameter int ADDR_W = 14
);
    logic              wrEn;
    logic [ADDR_W-1:0] addr_toRAM;
    logic [31:0]       data_toRAM;
    logic              rd_hit;
    logic [31:0]       rd_data;
    logic              interrupt;
    logic              irq_ack;
    logic [ADDR_W-1:0] vec_addr;
    logic [4:0]        active_id;

    modport master (
        output wrEn, addr_toRAM, data_toRAM, irq_ack,
        input  rd_hit, rd_data, interrupt, vec_addr, active_id
    );

    modport slave (
        input  wrEn, addr_toRAM, data_toRAM, irq_ack,
        output rd_hit, rd_data, interrupt, vec_addr, active_id
    );
endinterface

// File: rtl/vscpu_prio_enc.sv
// Fixed-priority encoder: index of the lowest set request bit plus a valid flag.
// Purely combinational, zero latency, no backpressure.
module vscpu_prio_enc #(
    parameter int W = 8
) (
    input  logic [W-1:0] req,
    output logic [4:0]   idx,
    output logic         vld
);

    always_comb begin
        idx = '0;
        vld = 1'b0;
        // Scanning downward lets the lowest set index be the last one written.
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 5'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vscpu_intc.sv
// Prioritised interrupt controller for VerySimpleCPU; pending->interrupt 1 cycle, edge->interrupt 2 cycles.
// No backpressure: a request is held until irq_ack, later arrivals wait in PENDING.
module vscpu_intc
    import vscpu_pkg::*;
#(
    parameter int                NUM_IRQ    = 8,
    parameter int                ADDR_W     = 14,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 14'h3FF0,
    parameter logic [ADDR_W-1:0] VEC_BASE   = 14'd60,
    parameter int                VEC_STRIDE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    vscpu_intc_if.slave        bus
);

    logic [NUM_IRQ-1:0] mask, edge_mode, pending, irq_prev;
    logic [NUM_IRQ-1:0] wdata, w1c, ack_clr, rise, pend_nxt;
    logic [ADDR_W-1:0]  offset, vec_q;
    logic [4:0]         id_q, win_id;
    logic               hit, win_vld, int_q, busy, wr;
    logic               wr_mask, wr_pend, wr_eoi, wr_edge;
    state_t             state;

    assign offset  = bus.addr_toRAM - BASE_ADDR;
    assign hit     = offset < ADDR_W'(5);
    assign wr      = bus.wrEn && hit;
    assign wr_mask = wr && (offset[2:0] == OFF_MASK);
    assign wr_pend = wr && (offset[2:0] == OFF_PEND);
    assign wr_eoi  = wr && (offset[2:0] == OFF_EOI);
    assign wr_edge = wr && (offset[2:0] == OFF_EDGE);
    assign wdata   = NUM_IRQ'(bus.data_toRAM);
    assign busy    = (state != IDLE);

    // Edge channels latch rising edges (set beats clear); level channels just follow the delayed input.
    assign rise     = irq_in & ~irq_prev;
    assign w1c      = wr_pend ? wdata : '0;
    assign ack_clr  = (state == REQ && bus.irq_ack) ? (NUM_IRQ'(1) << id_q) : '0;
    assign pend_nxt = (edge_mode & ((pending & ~(w1c | ack_clr)) | rise)) | (~edge_mode & irq_in);

    vscpu_prio_enc #(.W(NUM_IRQ)) u_prio (
        .req (pending & mask),
        .idx (win_id),
        .vld (win_vld)
    );

    always_comb begin
        bus.rd_data = '0;
        if (hit) begin
            case (offset[2:0])
                OFF_MASK: bus.rd_data = 32'(mask);
                OFF_PEND: bus.rd_data = 32'(pending);
                OFF_ACT:  bus.rd_data = busy ? {26'd0, 1'b1, id_q} : 32'd0;
                OFF_EDGE: bus.rd_data = 32'(edge_mode);
                default:  bus.rd_data = '0;
            endcase
        end
    end

    assign bus.rd_hit    = hit;
    assign bus.interrupt = int_q;
    assign bus.vec_addr  = vec_q;
    assign bus.active_id = id_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask      <= '0;
            edge_mode <= '0;
            pending   <= '0;
            irq_prev  <= '0;
            state     <= IDLE;
            int_q     <= 1'b0;
            vec_q     <= '0;
            id_q      <= '0;
        end else begin
            irq_prev <= irq_in;
            pending  <= pend_nxt;
            if (wr_mask) mask      <= wdata;
            if (wr_edge) edge_mode <= wdata;
            case (state)
                IDLE: if (win_vld) begin
                    state <= REQ;
                    int_q <= 1'b1;
                    id_q  <= win_id;
                    vec_q <= VEC_BASE + ADDR_W'(32'(win_id) * VEC_STRIDE);
                end
                REQ: if (bus.irq_ack) begin
                    state <= SERVICE;
                    int_q <= 1'b0;
                end
                SERVICE: if (wr_eoi) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vscpu_intc.sv
// Directed plus randomized bench for vscpu_intc against a cycle-level behavioural model of the register/handshake rules.
module tb_vscpu_intc;

    localparam int          N      = 8;
    localparam int          AW     = 14;
    localparam int unsigned BASE   = 32'h3FF0;
    localparam int unsigned NMASK  = 32'hFF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] irq_in = '0;

    vscpu_intc_if #(.ADDR_W(AW)) bus ();

    vscpu_intc u_dut (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural state: phase 0 = nothing outstanding, 1 = waiting for ack, 2 = handler running.
    int unsigned m_mask, m_edge, m_pend, m_prev, m_phase, m_int, m_vec, m_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned model_read(input int off);
        case (off)
            0:       return m_mask;
            1:       return m_pend;
            3:       return (m_phase != 0) ? (32 + m_id) : 0;
            4:       return m_edge;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        int unsigned n_pend, irq, wd, bit_v;
        int          off;
        bit          in_win, ack_eff;
        if (rst) begin
            m_mask = 0; m_edge = 0; m_pend = 0; m_prev = 0;
            m_phase = 0; m_int = 0; m_vec = 0; m_id = 0;
            return;
        end
        irq     = 32'(irq_in);
        wd      = bus.data_toRAM & NMASK;
        off     = int'(bus.addr_toRAM) - int'(BASE);
        in_win  = bus.wrEn && off >= 0 && off <= 4;
        ack_eff = bus.irq_ack && m_phase == 1;
        n_pend  = 0;
        for (int i = 0; i < N; i++) begin
            if ((m_edge >> i) & 1) begin
                bit_v = (m_pend >> i) & 1;
                if (in_win && off == 1 && ((wd >> i) & 1)) bit_v = 0;
                if (ack_eff && m_id == i) bit_v = 0;
                if (((irq >> i) & 1) && !((m_prev >> i) & 1)) bit_v = 1;
            end else begin
                bit_v = (irq >> i) & 1;
            end
            n_pend |= bit_v << i;
        end
        if (m_phase == 0) begin
            if ((m_pend & m_mask) != 0) begin
                for (int i = N - 1; i >= 0; i--)
                    if (((m_pend & m_mask) >> i) & 1) m_id = i;
                m_phase = 1;
                m_int   = 1;
                m_vec   = (60 + m_id * 4) % (1 << AW);
            end
        end else if (m_phase == 1) begin
            if (bus.irq_ack) begin
                m_phase = 2;
                m_int   = 0;
            end
        end else if (in_win && off == 2) begin
            m_phase = 0;
        end
        m_prev = irq;
        m_pend = n_pend;
        if (in_win && off == 0) m_mask = wd;
        if (in_win && off == 4) m_edge = wd;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("interrupt", 32'(bus.interrupt), m_int);
        check("vec_addr",  32'(bus.vec_addr),  m_vec);
        check("active_id", 32'(bus.active_id), m_id);
    endtask

    task automatic bus_write(input int off, input logic [31:0] d);
        bus.wrEn       = 1'b1;
        bus.addr_toRAM = AW'(BASE + off);
        bus.data_toRAM = d;
        tick();
        bus.wrEn = 1'b0;
    endtask

    task automatic ack();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
    endtask

    task automatic rd_expect(input int off, input logic [31:0] exp, input string tag);
        bus.addr_toRAM = AW'(BASE + off);
        #1;
        check(tag, bus.rd_data, exp);
    endtask

    initial begin
        logic [31:0] rexp;
        int          roff;
        bus.wrEn = 1'b0; bus.addr_toRAM = '0; bus.data_toRAM = '0; bus.irq_ack = 1'b0;

        tick(); tick();
        rst = 1'b0;
        check("rst_int", 32'(bus.interrupt), 0);
        check("rst_vec", 32'(bus.vec_addr), 0);
        rd_expect(0, 0, "rst_mask");
        rd_expect(1, 0, "rst_pend");
        rd_expect(4, 0, "rst_edge");
        rd_expect(3, 0, "rst_act");

        // Single edge pulse on channel 3.
        bus_write(0, 32'hFF);
        bus_write(4, 32'hFF);
        irq_in = 8'h08; tick(); irq_in = 8'h00;
        check("t1_int_early", 32'(bus.interrupt), 0);
        tick();
        check("t1_int", 32'(bus.interrupt), 1);
        check("t1_id", 32'(bus.active_id), 3);
        check("t1_vec", 32'(bus.vec_addr), 72);
        ack();
        check("t1_int_ack", 32'(bus.interrupt), 0);
        rd_expect(1, 32'h00, "t1_pend");
        rd_expect(3, 32'h23, "t1_act_busy");
        bus_write(2, 32'h0);
        rd_expect(3, 32'h00, "t1_act_eoi");

        // Simultaneous 5 and 2: fixed priority.
        irq_in = 8'h24; tick(); irq_in = 8'h00; tick();
        check("t2_vec2", 32'(bus.vec_addr), 68);
        ack();
        bus_write(2, 32'h0);
        check("t2_idle", 32'(bus.interrupt), 0);
        tick();
        check("t2_int5", 32'(bus.interrupt), 1);
        check("t2_vec5", 32'(bus.vec_addr), 80);
        ack(); bus_write(2, 32'h0);

        // Masked arrival, then unmask.
        bus_write(0, 32'h00);
        irq_in = 8'h02; tick(); irq_in = 8'h00; tick(); tick();
        check("t3_masked", 32'(bus.interrupt), 0);
        rd_expect(1, 32'h02, "t3_pend");
        bus_write(0, 32'h02);
        check("t3_wr_edge", 32'(bus.interrupt), 0);
        tick();
        check("t3_unmask", 32'(bus.interrupt), 1);
        ack(); bus_write(2, 32'h0);

        // Level mode re-request and drop.
        bus_write(0, 32'h01);
        bus_write(4, 32'h00);
        irq_in = 8'h01; tick(); tick();
        check("t4_int", 32'(bus.interrupt), 1);
        ack(); bus_write(2, 32'h0);
        check("t4_after_eoi", 32'(bus.interrupt), 0);
        tick();
        check("t4_rereq", 32'(bus.interrupt), 1);
        ack();
        irq_in = 8'h00; tick(); tick();
        bus_write(2, 32'h0); tick(); tick();
        check("t4_no_rereq", 32'(bus.interrupt), 0);

        // W1C colliding with a rising edge.
        bus_write(0, 32'h00);
        bus_write(4, 32'hFF);
        bus_write(1, 32'hFF);
        irq_in = 8'h10;
        bus_write(1, 32'h10);
        irq_in = 8'h00;
        rd_expect(1, 32'h10, "t5_set_wins");

        // Reset while requesting channel 6.
        bus_write(1, 32'hFF);
        bus_write(0, 32'h40);
        irq_in = 8'h40; tick(); irq_in = 8'h00; tick();
        check("t6_id", 32'(bus.active_id), 6);
        check("t6_vec", 32'(bus.vec_addr), 84);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t6_int", 32'(bus.interrupt), 0);
        check("t6_id_rst", 32'(bus.active_id), 0);
        rd_expect(0, 0, "t6_mask");
        rd_expect(1, 0, "t6_pend");

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            irq_in      = N'($urandom & $urandom);
            bus.irq_ack = ($urandom_range(0, 3) == 0);
            rst         = ($urandom_range(0, 199) == 0);
            bus.wrEn    = ($urandom_range(0, 3) == 0);
            roff        = $urandom_range(0, 6) - 1;
            if (bus.wrEn && $urandom_range(0, 1) == 1) roff = 2;
            bus.addr_toRAM = AW'(BASE + roff);
            bus.data_toRAM = $urandom;
            #1;
            rexp = (roff >= 0 && roff <= 4) ? model_read(roff) : 0;
            check("rnd_hit", 32'(bus.rd_hit), (roff >= 0 && roff <= 4) ? 1 : 0);
            check("rnd_rdata", bus.rd_data, rexp);
            tick();
        end
        bus.wrEn = 1'b0; bus.irq_ack = 1'b0; rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
